uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, FIFO depth in bytes; must be a power of two and at least 2.
REQ-002 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_Wr_DV, input, 1 bit: single-cycle write strobe.
REQ-005 The block SHALL have port i_Wr_Byte, input, 8 bits: byte written while i_Wr_DV=1.
REQ-006 The block SHALL have port o_Full, output, 1 bit: high when count=DEPTH.
REQ-007 The block SHALL have port o_Empty, output, 1 bit: high when count=0.
REQ-008 The block SHALL have port o_Count, output, clog2(DEPTH)+1 bits: bytes currently stored.
REQ-009 The block SHALL have port o_Overflow, output, 1 bit: sticky flag for a dropped write.
REQ-010 The block SHALL have port o_Tx_DV, output, 1 bit: launch pulse to the UART transmitter.
REQ-011 The block SHALL have port o_Tx_Byte, output, 8 bits: byte being launched; held stable until the next launch.
REQ-012 The block SHALL have port i_Tx_Active, input, 1 bit: transmitter busy.
REQ-013 The block SHALL have port i_Tx_Done, input, 1 bit: transmitter done.
REQ-014 The block SHALL have port o_Busy, output, 1 bit: high when the state is not IDLE or the FIFO is not empty.

Function
REQ-015 Writes SHALL be accepted iff i_Wr_DV=1 and count<DEPTH, evaluated before any same-cycle pop; there is no bypass.
REQ-016 A write with count=DEPTH SHALL be dropped, leave FIFO contents and count unchanged, and set o_Overflow.
REQ-017 o_Overflow SHALL be cleared only by reset.
REQ-018 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-019 Count SHALL update as +1 on write only, -1 on pop only, and be unchanged on simultaneous write and pop.
REQ-020 Flags and o_Count SHALL be registered and reflect the state after the current edge.
REQ-021 The state machine SHALL have states IDLE, WAIT_ACTIVE and WAIT_DONE.
REQ-022 IDLE -> WAIT_ACTIVE SHALL occur when count>0, i_Tx_Active=0 and i_Tx_Done=0; on that edge the block pops the head byte into o_Tx_Byte, asserts o_Tx_DV for exactly one cycle, and increments the read pointer.
REQ-023 WAIT_ACTIVE -> WAIT_DONE SHALL occur on i_Tx_Active=1; the block holds in WAIT_ACTIVE with o_Tx_DV=0 indefinitely otherwise.
REQ-024 WAIT_DONE -> IDLE SHALL occur on i_Tx_Done=1.
REQ-025 The i_Tx_Done=0 guard in IDLE SHALL prevent a launch while the transmitter is still in its post-stop-bit cleanup, so no launch pulse is lost.
REQ-026 o_Tx_DV SHALL never be asserted in two consecutive cycles.
REQ-027 o_Tx_DV SHALL never be asserted outside an IDLE -> WAIT_ACTIVE transition.
REQ-028 Latency SHALL be as follows: with the FIFO empty, the state IDLE and the transmitter idle, a write accepted at edge N produces o_Tx_DV=1 in the cycle following edge N+1.
REQ-029 Bytes SHALL be launched in strict write order with no duplication or loss of accepted bytes.
REQ-030 A write in the same cycle as the launch of the last stored byte SHALL be stored and launched after the current frame completes.

Reset
REQ-031 On i_Reset=1 at a clock edge the block SHALL set state=IDLE, both pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00 and o_Busy=0.
REQ-032 Reset SHALL take priority over any simultaneous write or launch.
REQ-033 Reset mid-frame SHALL discard all stored bytes.
REQ-034 After a reset mid-frame, the block SHALL not launch until the transmitter shows i_Tx_Active=0 and i_Tx_Done=0.
REQ-035 FIFO memory contents SHALL not require reset.

Verification
REQ-036 The bench SHALL cover single byte: write 8'hA5 into an idle block connected to uart_tx with CLKS_PER_BIT=2 -> one o_Tx_DV pulse with o_Tx_Byte=A5 and a serial frame of 0, 1,0,1,0,0,1,0,1, 1 (LSB first) at 2 clocks per bit.
REQ-037 The bench SHALL cover burst: write 5 bytes 01..05 back-to-back -> 5 frames in order, each o_Tx_DV issued only after i_Tx_Done has fallen, with o_Count falling 5..0.
REQ-038 The bench SHALL cover fill and overflow: hold the transmitter busy and write 17 bytes with DEPTH=16 -> o_Full=1, o_Count=16, o_Overflow=1, the 17th byte never transmitted and the first 16 transmitted in order.
REQ-039 The bench SHALL cover wrap-around: stream 40 bytes of an incrementing pattern at arbitrary write spacing -> all 40 received in order with o_Overflow=0.
REQ-040 The bench SHALL cover simultaneous events: write while the last byte launches -> count goes 1 -> 1, and the new byte is sent next.
REQ-041 The bench SHALL cover reset mid-operation: assert i_Reset during WAIT_DONE with 3 bytes queued -> o_Count=0 and o_Empty=1 on the next cycle, and no further o_Tx_DV after the current frame ends.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-side and transmitter-side handshake bundle for the UART transmit FIFO.
// Signal names are written from the FIFO's point of view.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          i_Wr_DV;
  logic [7:0]    i_Wr_Byte;
  logic          o_Full;
  logic          o_Empty;
  logic [CW-1:0] o_Count;
  logic          o_Overflow;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          i_Tx_Active;
  logic          i_Tx_Done;
  logic          o_Busy;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
  );

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one launch pulse per stored byte, in
// write order, only once the transmitter is fully idle (not active, not done).
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACTIVE = 2'd1,
    WAIT_DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;
  logic          busy_q;

  logic          wr_ok_c;
  logic          pop_c;
  logic          busy_state_c;
  logic [CW-1:0] count_nxt_c;

  // Write acceptance uses the pre-pop count, so a full FIFO drops a write even
  // when a launch frees a slot on the same edge.
  always_comb begin
    wr_ok_c      = bus.i_Wr_DV && (count != CW'(DEPTH));
    pop_c        = (state == IDLE) && (count != '0) &&
                   !bus.i_Tx_Active && !bus.i_Tx_Done;
    busy_state_c = pop_c || (state == WAIT_ACTIVE) ||
                   ((state == WAIT_DONE) && !bus.i_Tx_Done);
    count_nxt_c  = count;
    if (wr_ok_c && !pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (!wr_ok_c && pop_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Storage has no reset; only pointers and count define valid content.
  always_ff @(posedge i_Clock) begin
    if (wr_ok_c) begin
      mem[wr_ptr] <= bus.i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      if (wr_ok_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bus.i_Wr_DV && !wr_ok_c) begin
        overflow_q <= 1'b1;
      end
      count   <= count_nxt_c;
      full_q  <= (count_nxt_c == CW'(DEPTH));
      empty_q <= (count_nxt_c == '0);
      busy_q  <= (count_nxt_c != '0) || busy_state_c;

      case (state)
        IDLE: begin
          if (pop_c) begin
            tx_byte_q <= mem[rd_ptr];
            tx_dv_q   <= 1'b1;
            rd_ptr    <= rd_ptr + AW'(1);
            state     <= WAIT_ACTIVE;
          end
        end
        WAIT_ACTIVE: begin
          if (bus.i_Tx_Active) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.i_Tx_Done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Full     = full_q;
  assign bus.o_Empty    = empty_q;
  assign bus.o_Count    = count;
  assign bus.o_Overflow = overflow_q;
  assign bus.o_Tx_DV    = tx_dv_q;
  assign bus.o_Tx_Byte  = tx_byte_q;
  assign bus.o_Busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo driving a behavioural 2-clocks-per-bit UART
// transmitter that holds Tx_Done for two cycles after the stop bit.
module tb_uart_tx_fifo;
  localparam int unsigned DEPTH = 16;
  localparam int          CPB   = 2;

  logic       i_Clock   = 1'b0;
  logic       i_Reset   = 1'b1;
  logic       hold_busy = 1'b0;
  int         total     = 0;
  int         bad       = 0;
  int         dv_seen   = 0;
  int         dv_mark   = 0;
  logic       prev_dv   = 1'b0;
  logic [7:0] rx_q[$];
  logic [9:0] frame_exp;

  logic       m_active = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_serial = 1'b1;
  int         m_phase  = 0;
  int         m_cnt    = 0;
  logic [3:0] m_bit    = 4'd0;
  logic [9:0] m_frame  = '1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clock = ~i_Clock;

  assign bus.i_Tx_Active = m_active | hold_busy;
  assign bus.i_Tx_Done   = m_done;

  // Transmitter model: launch pulses arriving outside its idle phase are lost.
  always @(posedge i_Clock) begin
    case (m_phase)
      0: begin
        m_done <= 1'b0;
        if (bus.o_Tx_DV) begin
          m_frame  <= {1'b1, bus.o_Tx_Byte, 1'b0};
          m_serial <= 1'b0;
          m_active <= 1'b1;
          m_bit    <= 4'd0;
          m_cnt    <= 0;
          m_phase  <= 1;
        end
      end
      1: begin
        if (m_cnt == CPB - 1) begin
          m_cnt <= 0;
          if (m_bit == 4'd9) begin
            m_serial <= 1'b1;
            m_active <= 1'b0;
            m_done   <= 1'b1;
            m_phase  <= 2;
          end else begin
            m_bit    <= m_bit + 4'd1;
            m_serial <= m_frame[m_bit + 4'd1];
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      default: begin
        m_done  <= 1'b1;
        m_phase <= 0;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every launch pulse: record the byte, and it must be isolated and must
  // only happen while the transmitter is neither active nor done.
  always @(negedge i_Clock) begin
    if (bus.o_Tx_DV === 1'b1) begin
      rx_q.push_back(bus.o_Tx_Byte);
      dv_seen++;
      chk("dv_back_to_back", 32'(prev_dv), 32'd0);
      chk("dv_tx_done_low", 32'(bus.i_Tx_Done), 32'd0);
      chk("dv_tx_active_low", 32'(bus.i_Tx_Active), 32'd0);
    end
    prev_dv = bus.o_Tx_DV;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic wr(input logic [7:0] b);
    bus.i_Wr_DV   = 1'b1;
    bus.i_Wr_Byte = b;
    @(negedge i_Clock);
    bus.i_Wr_DV   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((bus.o_Busy !== 1'b0 || m_active || m_done || m_phase != 0) && n < budget) begin
      @(negedge i_Clock);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_dv(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while (bus.o_Tx_DV !== 1'b1 && n < budget);
    chk(tag, 32'(bus.o_Tx_DV), 32'd1);
  endtask

  task automatic chk_rx(input string tag, input logic [7:0] first, input int n);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      chk(tag, 32'(rx_q[i]), 32'(first + 8'(i)));
    end
    rx_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Wr_DV   = 1'b0;
    bus.i_Wr_Byte = 8'h00;

    // Reset state
    i_Reset = 1'b1;
    tick(3);
    chk("rst_count", 32'(bus.o_Count), 32'd0);
    chk("rst_empty", 32'(bus.o_Empty), 32'd1);
    chk("rst_full", 32'(bus.o_Full), 32'd0);
    chk("rst_ovf", 32'(bus.o_Overflow), 32'd0);
    chk("rst_dv", 32'(bus.o_Tx_DV), 32'd0);
    chk("rst_byte", 32'(bus.o_Tx_Byte), 32'h00);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    i_Reset = 1'b0;
    tick(2);

    // Single byte: launch one cycle after the write, then the serial frame
    wr(8'hA5);
    chk("lat_count", 32'(bus.o_Count), 32'd1);
    chk("lat_dv_early", 32'(bus.o_Tx_DV), 32'd0);
    chk("lat_busy", 32'(bus.o_Busy), 32'd1);
    tick(1);
    chk("lat_dv", 32'(bus.o_Tx_DV), 32'd1);
    chk("lat_byte", 32'(bus.o_Tx_Byte), 32'hA5);
    chk("lat_count_pop", 32'(bus.o_Count), 32'd0);
    chk("lat_empty", 32'(bus.o_Empty), 32'd1);
    frame_exp = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      tick(1);
      chk("frame_bit", 32'(m_serial), 32'(frame_exp[b]));
      tick(1);
    end
    wait_idle("idle_single", 200);
    chk_rx("single", 8'hA5, 1);

    // Burst of five queued behind a busy transmitter, count drains 5..0
    hold_busy = 1'b1;
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("burst_count5", 32'(bus.o_Count), 32'd5);
    hold_busy = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      wait_dv("burst_dv", 100);
      chk("burst_count", 32'(bus.o_Count), 32'(k));
    end
    wait_idle("idle_burst", 200);
    chk_rx("burst", 8'h01, 5);

    // Fill to DEPTH then one extra write is dropped
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    chk("fill_full", 32'(bus.o_Full), 32'd1);
    chk("fill_count", 32'(bus.o_Count), 32'd16);
    chk("fill_ovf_pre", 32'(bus.o_Overflow), 32'd0);
    wr(8'hEE);
    chk("ovf_set", 32'(bus.o_Overflow), 32'd1);
    chk("ovf_count", 32'(bus.o_Count), 32'd16);
    chk("ovf_full", 32'(bus.o_Full), 32'd1);
    hold_busy = 1'b0;
    wait_idle("idle_fill", 1500);
    chk("ovf_sticky", 32'(bus.o_Overflow), 32'd1);
    chk("fill_empty", 32'(bus.o_Empty), 32'd1);
    chk_rx("fill", 8'h10, 16);

    // Only reset clears the overflow flag
    i_Reset = 1'b1;
    tick(1);
    i_Reset = 1'b0;
    chk("ovf_clear", 32'(bus.o_Overflow), 32'd0);
    tick(2);

    // Pointer wrap with irregular write spacing
    for (int i = 0; i < 40; i++) begin
      wr(8'h40 + 8'(i));
      tick(10 + (i * 7) % 23);
    end
    wait_idle("idle_wrap", 3000);
    chk("wrap_ovf", 32'(bus.o_Overflow), 32'd0);
    chk_rx("wrap", 8'h40, 40);

    // Write on the same edge the last stored byte launches
    wr(8'h77);
    chk("simul_count_a", 32'(bus.o_Count), 32'd1);
    wr(8'h78);
    chk("simul_count_b", 32'(bus.o_Count), 32'd1);
    chk("simul_dv", 32'(bus.o_Tx_DV), 32'd1);
    chk("simul_byte", 32'(bus.o_Tx_Byte), 32'h77);
    wait_idle("idle_simul", 300);
    chk_rx("simul", 8'h77, 2);

    // Reset while waiting for done with three bytes still queued
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    hold_busy = 1'b0;
    wait_dv("mid_launch", 10);
    chk("mid_count", 32'(bus.o_Count), 32'd3);
    tick(4);
    chk("mid_active", 32'(m_active), 32'd1);
    i_Reset = 1'b1;
    tick(1);
    i_Reset = 1'b0;
    chk("mid_rst_count", 32'(bus.o_Count), 32'd0);
    chk("mid_rst_empty", 32'(bus.o_Empty), 32'd1);
    chk("mid_rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("mid_rst_byte", 32'(bus.o_Tx_Byte), 32'h00);
    dv_mark = dv_seen;
    wait_idle("idle_mid", 200);
    tick(10);
    chk("mid_no_launch", 32'(dv_seen), 32'(dv_mark));
    chk_rx("mid", 8'hC0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
